// File: rtl/fetch_sequencer_pkg.sv
// +--------------------------------------------------------------------+
// | fetch_sequencer_pkg : shared encodings for the fetch stage          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    LATCH     = 2'd2,
    VALID     = 2'd3
  } fetch_state_e;

  localparam int         PKG_LONG_BIT = 7;
  localparam logic [7:0] PKG_RESET_PC = 8'h00;

endpackage : fetch_sequencer_pkg

`default_nettype wire

// File: rtl/fetch_sequencer_pc_counter.sv
// +--------------------------------------------------------------------+
// | pc_counter : fetch address register with branch load and increment |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module pc_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              res,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Load takes precedence so a redirect never also advances; increment wraps.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : pc_counter

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// +--------------------------------------------------------------------+
// | fetch_sequencer : instruction fetch FSM feeding opcode/operand regs |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PKG_RESET_PC),
  parameter int                LONG_BIT = PKG_LONG_BIT
) (
  input  logic              clk,
  input  logic              res,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] op_d,
  output logic              op_en,
  output logic [DATA_W-1:0] arg_d,
  output logic              arg_en,
  output logic              instr_valid
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] op_byte_q, op_byte_d;
  logic [DATA_W-1:0] arg_byte_q, arg_byte_d;
  logic              op_en_q, op_en_d;
  logic              arg_en_q, arg_en_d;
  logic              valid_q, valid_d;
  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_w;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk         (clk),
    .res         (res),
    .load_i      (pc_load),
    .load_addr_i (branch_addr),
    .inc_i       (pc_inc),
    .pc_o        (pc_w)
  );

  always_comb begin
    state_d    = state_q;
    op_byte_d  = op_byte_q;
    arg_byte_d = arg_byte_q;
    op_en_d    = 1'b0;
    arg_en_d   = 1'b0;
    valid_d    = valid_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;

    // A redirect discards any same-cycle memory data and overrides stall.
    if (branch_en) begin
      pc_load = 1'b1;
      state_d = FETCH_OP;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        FETCH_OP: begin
          if (mem_rdy) begin
            op_byte_d = mem_data;
            op_en_d   = 1'b1;
            pc_inc    = 1'b1;
            state_d   = mem_data[LONG_BIT] ? FETCH_ARG : LATCH;
          end
        end
        FETCH_ARG: begin
          if (mem_rdy) begin
            arg_byte_d = mem_data;
            arg_en_d   = 1'b1;
            pc_inc     = 1'b1;
            state_d    = LATCH;
          end
        end
        LATCH: begin
          state_d = VALID;
          valid_d = 1'b1;
        end
        VALID: begin
          if (!stall) begin
            state_d = FETCH_OP;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = FETCH_OP;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= FETCH_OP;
      op_byte_q  <= '0;
      arg_byte_q <= '0;
      op_en_q    <= 1'b0;
      arg_en_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_byte_q  <= op_byte_d;
      arg_byte_q <= arg_byte_d;
      op_en_q    <= op_en_d;
      arg_en_q   <= arg_en_d;
      valid_q    <= valid_d;
    end
  end

  // Request is gated by reset so memory sees it drop immediately.
  assign mem_req     = res && ((state_q == FETCH_OP) || (state_q == FETCH_ARG));
  assign mem_addr    = pc_w;
  assign pc          = pc_w;
  assign op_d        = op_byte_q;
  assign op_en       = op_en_q;
  assign arg_d       = arg_byte_q;
  assign arg_en      = arg_en_q;
  assign instr_valid = valid_q;

endmodule : fetch_sequencer

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_fetch_sequencer : directed scoreboard bench for fetch_sequencer  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fetch_sequencer;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] arg;
  } exp_t;

  logic       clk;
  logic       res;
  logic       stall;
  logic       branch_en;
  logic [7:0] branch_addr;
  logic       mem_rdy;
  logic [7:0] mem_data;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] pc;
  logic [7:0] op_d;
  logic       op_en;
  logic [7:0] arg_d;
  logic       arg_en;
  logic       instr_valid;

  logic [7:0] mem [0:255];
  exp_t       sb_q[$];
  int         n_cmp;
  int         n_err;

  fetch_sequencer dut (
    .clk         (clk),
    .res         (res),
    .stall       (stall),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .mem_rdy     (mem_rdy),
    .mem_data    (mem_data),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .pc          (pc),
    .op_d        (op_d),
    .op_en       (op_en),
    .arg_d       (arg_d),
    .arg_en      (arg_en),
    .instr_valid (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb mem_data = mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      tick();
      n++;
    end
    chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic sb_pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_op"}, {24'd0, op_d}, {24'd0, e.op});
      chk({tag, "_arg"}, {24'd0, arg_d}, {24'd0, e.arg});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12;
    mem[8'h01] = 8'h85;
    mem[8'h02] = 8'h3C;
    mem[8'h03] = 8'h21;
    mem[8'h04] = 8'h9A;
    mem[8'h05] = 8'h5D;
    mem[8'h40] = 8'h33;
    res = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_addr = 8'h00; mem_rdy = 1'b1;

    // Reset held for two edges
    tick(); tick();
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_op_en", {31'd0, op_en}, 32'd0);
    chk("rst_arg_en", {31'd0, arg_en}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    res = 1'b1;
    #1;
    chk("rel_req", {31'd0, mem_req}, 32'd1);
    chk("rel_addr", {24'd0, mem_addr}, 32'h00);

    // Short opcode, zero-wait: op_en in cycle 2, valid in cycle 3
    sb_q.push_back('{op: 8'h12, arg: 8'h00});
    tick();
    chk("s_op_en", {31'd0, op_en}, 32'd1);
    chk("s_op_d", {24'd0, op_d}, 32'h12);
    chk("s_arg_en2", {31'd0, arg_en}, 32'd0);
    chk("s_valid2", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("s_valid3", {31'd0, instr_valid}, 32'd1);
    chk("s_op_en3", {31'd0, op_en}, 32'd0);
    chk("s_arg_en3", {31'd0, arg_en}, 32'd0);
    chk("s_pc", {24'd0, pc}, 32'h01);
    chk("s_req_valid", {31'd0, mem_req}, 32'd0);
    sb_pop_check("short");

    // Long opcode: op_en cycle 2, arg_en cycle 3, valid cycle 4
    sb_q.push_back('{op: 8'h85, arg: 8'h3C});
    tick();
    chk("l_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("l_addr1", {24'd0, mem_addr}, 32'h01);
    tick();
    chk("l_op_en", {31'd0, op_en}, 32'd1);
    chk("l_arg_en2", {31'd0, arg_en}, 32'd0);
    chk("l_op_d", {24'd0, op_d}, 32'h85);
    tick();
    chk("l_arg_en", {31'd0, arg_en}, 32'd1);
    chk("l_op_en3", {31'd0, op_en}, 32'd0);
    chk("l_arg_d", {24'd0, arg_d}, 32'h3C);
    chk("l_valid3", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("l_valid4", {31'd0, instr_valid}, 32'd1);
    chk("l_pc", {24'd0, pc}, 32'h03);
    sb_pop_check("long");

    // Memory wait for three cycles, then stall in VALID
    sb_q.push_back('{op: 8'h21, arg: 8'h3C});
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w_addr", {24'd0, mem_addr}, 32'h03);
      chk("w_req", {31'd0, mem_req}, 32'd1);
      chk("w_op_en", {31'd0, op_en}, 32'd0);
    end
    mem_rdy = 1'b1;
    stall = 1'b1;
    wait_valid(6);
    sb_pop_check("wait");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_valid", {31'd0, instr_valid}, 32'd1);
      chk("st_req", {31'd0, mem_req}, 32'd0);
      chk("st_pc", {24'd0, pc}, 32'h04);
    end
    stall = 1'b0;
    tick();
    chk("st_release", {31'd0, instr_valid}, 32'd0);
    chk("st_addr", {24'd0, mem_addr}, 32'h04);

    // Branch collides with operand fetch
    tick();
    chk("b_op_d", {24'd0, op_d}, 32'h9A);
    chk("b_addr_arg", {24'd0, mem_addr}, 32'h05);
    branch_en = 1'b1;
    branch_addr = 8'h40;
    tick();
    branch_en = 1'b0;
    chk("b_arg_en", {31'd0, arg_en}, 32'd0);
    chk("b_valid", {31'd0, instr_valid}, 32'd0);
    chk("b_addr", {24'd0, mem_addr}, 32'h40);
    chk("b_arg_keep", {24'd0, arg_d}, 32'h3C);
    sb_q.push_back('{op: 8'h33, arg: 8'h3C});
    wait_valid(6);
    sb_pop_check("branch");

    // Branch in VALID under stall redirects to FF; long op wraps to 00
    mem[8'hFF] = 8'h80;
    mem[8'h00] = 8'h07;
    stall = 1'b1;
    branch_en = 1'b1;
    branch_addr = 8'hFF;
    tick();
    branch_en = 1'b0;
    stall = 1'b0;
    chk("wr_valid", {31'd0, instr_valid}, 32'd0);
    chk("wr_addr", {24'd0, mem_addr}, 32'hFF);
    tick();
    chk("wr_addr_arg", {24'd0, mem_addr}, 32'h00);
    sb_q.push_back('{op: 8'h80, arg: 8'h07});
    wait_valid(6);
    chk("wr_pc", {24'd0, pc}, 32'h01);
    sb_pop_check("wrap");

    // Reset mid-fetch drops request immediately
    tick();
    chk("mr_req", {31'd0, mem_req}, 32'd1);
    res = 1'b0;
    #1;
    chk("mr_req_drop", {31'd0, mem_req}, 32'd0);
    tick();
    chk("mr_pc", {24'd0, pc}, 32'h00);
    chk("mr_op_d", {24'd0, op_d}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_sequencer

`default_nettype wire
